// File: rtl/message_scroller_pkg.sv
// Shared constants, FSM state type and the wrap-around index helper for the
// message scroller.
package message_scroller_pkg;

   localparam int CHAR_W    = 4;
   localparam int MSG_DEPTH = 16;
   localparam int PTR_W     = $clog2(MSG_DEPTH);
   localparam int LEN_W     = PTR_W + 1;

   typedef enum logic [1:0] {
      RUN,
      LOAD,
      COMMIT
   } state_t;

   // (p + k) mod len using up to three conditional subtractions, so that
   // messages of 1..3 characters repeat across all four digits.
   // NOTE: blocking assignments are correct here; a function body is pure
   // combinational evaluation, never clocked state.
   function automatic logic [PTR_W-1:0] wrap_index(input logic [PTR_W-1:0] p,
                                                   input logic [1:0]       k,
                                                   input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] v;
      v = LEN_W'(p) + LEN_W'(k);
      for (int i = 0; i < 3; i++) begin
         if (v >= len) v = v - len;
      end
      return v[PTR_W-1:0];
   endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Auto-scroll timer and step-button edge detector, merged into one advance
// pulse that is only honoured while the scroller is running.
module scroll_tick_gen #(
   parameter int TICK_DIV = 4000000
) (
   input  logic clk,
   input  logic reset,
   input  logic auto_en,
   input  logic step_btn,
   input  logic run,
   input  logic clear,
   output logic advance
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             step_q;
   logic             tick;
   logic             step_ev;

   assign tick    = auto_en && (cnt == TERM);
   assign step_ev = step_btn && !step_q;
   // A coincident tick and step collapse into a single advance.
   assign advance = run && (tick || step_ev);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         step_q <= 1'b0;
      end else begin
         step_q <= step_btn;
         if (!auto_en || clear || tick) cnt <= '0;
         else                           cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/message_scroller.sv
// Loadable 16-character message store with a scroll position, feeding four
// registered digit codes to the LED driver.
module message_scroller
   import message_scroller_pkg::*;
#(
   parameter int TICK_DIV = 4000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [CHAR_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic              step_btn,
   input  logic              auto_en,
   input  logic              dir,
   output logic [CHAR_W-1:0] dig3,
   output logic [CHAR_W-1:0] dig2,
   output logic [CHAR_W-1:0] dig1,
   output logic [CHAR_W-1:0] dig0,
   output logic [LEN_W-1:0]  msg_len,
   output logic              loading
);

   state_t            state, state_next;
   logic [CHAR_W-1:0] mem [MSG_DEPTH];
   logic [LEN_W-1:0]  wptr;
   logic [PTR_W-1:0]  pos, pos_next, waddr;
   logic [LEN_W-1:0]  len_m1;
   logic              accept, advance;

   assign wr_ready = (state != COMMIT);
   assign accept   = wr_valid && wr_ready;
   assign waddr    = (state == RUN) ? '0 : wptr[PTR_W-1:0];

   scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .auto_en (auto_en),
      .step_btn(step_btn),
      .run     (state == RUN),
      .clear   (state == COMMIT),
      .advance (advance)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      loading    = 1'b0;
      case (state)
         RUN: begin
            if (accept) state_next = wr_last ? COMMIT : LOAD;
         end
         LOAD: begin
            loading = 1'b1;
            if (accept && (wr_last || wptr == LEN_W'(MSG_DEPTH - 1))) state_next = COMMIT;
         end
         COMMIT:  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // NOTE: the message memory is deliberately reset; its power-up contents
   // (0..F) are the default display, so it must be flops, not a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= CHAR_W'(i);
         wptr <= '0;
      end else if (accept) begin
         mem[waddr] <= wr_data;
         wptr       <= (state == RUN) ? LEN_W'(1) : wptr + LEN_W'(1);
      end
   end

   assign len_m1 = msg_len - LEN_W'(1);

   always_comb begin
      pos_next = pos;
      if (!dir) pos_next = (LEN_W'(pos) == len_m1) ? '0 : pos + PTR_W'(1);
      else      pos_next = (pos == '0) ? len_m1[PTR_W-1:0] : pos - PTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msg_len <= LEN_W'(MSG_DEPTH);
         pos     <= '0;
      end else if (state == COMMIT) begin
         msg_len <= wptr;
         pos     <= '0;
      end else if (advance) begin
         pos <= pos_next;
      end
   end

   // Digits refresh only while running, so a load in progress stays frozen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dig3 <= CHAR_W'(0);
         dig2 <= CHAR_W'(1);
         dig1 <= CHAR_W'(2);
         dig0 <= CHAR_W'(3);
      end else if (state == RUN) begin
         dig3 <= mem[wrap_index(pos, 2'd0, msg_len)];
         dig2 <= mem[wrap_index(pos, 2'd1, msg_len)];
         dig1 <= mem[wrap_index(pos, 2'd2, msg_len)];
         dig0 <= mem[wrap_index(pos, 2'd3, msg_len)];
      end
   end

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench: a behavioural model of the message/scroll rules is
// compared against the DUT every cycle, with literal checkpoints on top.
module tb_message_scroller;

   localparam int TB_TICK = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid, wr_ready, wr_last;
   logic [3:0] wr_data;
   logic       step_btn, auto_en, dir;
   logic [3:0] dig3, dig2, dig1, dig0;
   logic [4:0] msg_len;
   logic       loading;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   message_scroller #(.TICK_DIV(TB_TICK)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_data (wr_data),
      .wr_last (wr_last),
      .step_btn(step_btn),
      .auto_en (auto_en),
      .dir     (dir),
      .dig3    (dig3),
      .dig2    (dig2),
      .dig1    (dig1),
      .dig0    (dig0),
      .msg_len (msg_len),
      .loading (loading)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [3:0] m_mem [16];
   logic [3:0] e_dig [4];
   int m_len, m_pos, m_cnt, m_wptr, m_phase;   // phase: 0 run, 1 load, 2 commit
   bit m_step_q;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 4'(i);
      for (int k = 0; k < 4; k++) e_dig[k] = 4'(k);
      m_len = 16; m_pos = 0; m_cnt = 0; m_wptr = 0; m_phase = 0; m_step_q = 1'b0;
   endtask

   task automatic model_step();
      bit tick, stp, acc;
      tick = auto_en && (m_cnt == TB_TICK - 1);
      stp  = step_btn && !m_step_q;
      acc  = wr_valid && (m_phase != 2);
      if (m_phase == 0)
         for (int k = 0; k < 4; k++) e_dig[k] = m_mem[(m_pos + k) % m_len];
      m_step_q = step_btn;
      m_cnt = (auto_en && m_phase != 2) ? (m_cnt + 1) % TB_TICK : 0;
      case (m_phase)
         0: begin
            if (tick || stp)
               m_pos = dir ? (m_pos + m_len - 1) % m_len : (m_pos + 1) % m_len;
            if (acc) begin
               m_mem[0] = wr_data; m_wptr = 1;
               m_phase = wr_last ? 2 : 1;
            end
         end
         1: begin
            if (acc) begin
               m_mem[m_wptr] = wr_data; m_wptr++;
               if (wr_last || m_wptr == 16) m_phase = 2;
            end
         end
         default: begin
            m_len = m_wptr; m_pos = 0; m_phase = 0;
         end
      endcase
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en && reset === 1'b1) begin
         check("dig3",     32'(dig3),     32'(e_dig[0]));
         check("dig2",     32'(dig2),     32'(e_dig[1]));
         check("dig1",     32'(dig1),     32'(e_dig[2]));
         check("dig0",     32'(dig0),     32'(e_dig[3]));
         check("msg_len",  32'(msg_len),  32'(m_len));
         check("wr_ready", 32'(wr_ready), 32'(m_phase != 2));
         check("loading",  32'(loading),  32'(m_phase == 1));
      end
   end

   task automatic check_digs(input string name, input logic [15:0] exp);
      check(name, 32'({dig3, dig2, dig1, dig0}), 32'(exp));
      check({name, "_model"}, 32'({e_dig[0], e_dig[1], e_dig[2], e_dig[3]}), 32'(exp));
   endtask

   // Offer a beat at the current negedge and return at the negedge after it is taken.
   task automatic send_beat(input logic [3:0] data, input logic last);
      bit acc = 1'b0;
      wr_valid = 1'b1; wr_data = data; wr_last = last;
      for (int t = 0; t < 8; t++) begin
         acc = wr_ready;
         @(negedge clk);
         if (acc) break;
      end
      if (!acc) check("beat_accept", 32'(acc), 32'd1);
   endtask

   task automatic step_pulse();
      step_btn = 1'b1;
      @(negedge clk);
      step_btn = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
      step_btn = 1'b0; auto_en = 1'b0; dir = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_en = 1'b1;

      // Reset state
      check_digs("reset_digs", 16'h0123);
      check("reset_len",   32'(msg_len),  32'd16);
      check("reset_ready", 32'(wr_ready), 32'd1);
      check("reset_load",  32'(loading),  32'd0);

      // Auto scroll, left: advance every 4 cycles, full wrap after 16 advances
      auto_en = 1'b1; dir = 1'b0;
      repeat (5)  @(negedge clk); check_digs("auto_1", 16'h1234);
      repeat (4)  @(negedge clk); check_digs("auto_2", 16'h2345);
      repeat (52) @(negedge clk); check_digs("auto_15", 16'hF012);
      repeat (4)  @(negedge clk); check_digs("auto_16", 16'h0123);
      auto_en = 1'b0;
      @(negedge clk);

      // Load A,B,C
      send_beat(4'hA, 1'b0); check("abc_load1", 32'(loading), 32'd1);
      send_beat(4'hB, 1'b0); check("abc_load2", 32'(loading), 32'd1);
      send_beat(4'hC, 1'b1);
      check("abc_commit_ready", 32'(wr_ready), 32'd0);
      check("abc_commit_load",  32'(loading),  32'd0);
      wr_valid = 1'b0; wr_last = 1'b0;
      @(negedge clk); check("abc_len", 32'(msg_len), 32'd3);
      @(negedge clk); check_digs("abc_digs", 16'hABCA);
      dir = 1'b1; step_btn = 1'b1;
      @(negedge clk); step_btn = 1'b0;
      @(negedge clk); check_digs("abc_right", 16'hCABC);

      // 17 beats without wr_last: beat 16 forces commit, beat 17 restarts at 0
      for (int i = 0; i < 16; i++) send_beat(4'((i + 7) & 15), 1'b0);
      check("force_commit_ready", 32'(wr_ready), 32'd0);
      send_beat(4'h7, 1'b0);
      check("force_len",  32'(msg_len), 32'd16);
      check("force_load", 32'(loading), 32'd1);
      check_digs("force_digs", 16'h789A);
      send_beat(4'h5, 1'b1);
      wr_valid = 1'b0; wr_last = 1'b0;
      repeat (2) @(negedge clk);
      check("len2_len", 32'(msg_len), 32'd2);
      check_digs("len2_digs", 16'h7575);

      // Single-character message
      send_beat(4'hE, 1'b1);
      wr_valid = 1'b0; wr_last = 1'b0;
      repeat (2) @(negedge clk);
      check("len1_len", 32'(msg_len), 32'd1);
      check_digs("len1_digs", 16'hEEEE);
      step_pulse();
      check_digs("len1_step", 16'hEEEE);

      // Reset in the middle of a load
      send_beat(4'h9, 1'b0);
      send_beat(4'h8, 1'b0);
      wr_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_digs("rst_load_digs", 16'h0123);
      check("rst_load_len",   32'(msg_len),  32'd16);
      check("rst_load_ready", 32'(wr_ready), 32'd1);
      check("rst_load_load",  32'(loading),  32'd0);
      @(negedge clk);
      check_digs("rst_load_digs2", 16'h0123);

      // Step rising edge coinciding with an auto tick, then held high
      auto_en = 1'b1; dir = 1'b0;
      repeat (3) @(negedge clk);
      step_btn = 1'b1;
      @(negedge clk);
      auto_en = 1'b0;
      repeat (100) @(negedge clk);
      check_digs("coincide", 16'h1234);
      step_btn = 1'b0;
      @(negedge clk);

      // Right scroll wrapping through zero on a full message
      dir = 1'b1;
      step_pulse();
      step_pulse();
      check_digs("right_wrap", 16'hF012);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
